// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the CPU control unit.
// CTRL_HALT_EN adds the HALT state used to stop on illegal instructions.
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      S_WAIT   = 3'd0,
      S_DECODE = 3'd1,
      S_WIMM   = 3'd2,
      S_GETA   = 3'd3,
      S_GETB   = 3'd4,
      S_ALU    = 3'd5,
      S_WREG   = 3'd6
`ifdef CTRL_HALT_EN
      , S_HALT = 3'd7
`endif
   } state_t;

   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;

   localparam logic [1:0] OP_MOV_REG = 2'b00;
   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_CMP     = 2'b01;

   localparam logic [1:0] VSEL_NONE = 2'b00;
   localparam logic [1:0] VSEL_IMM8 = 2'b01;
   localparam logic [1:0] VSEL_C    = 2'b11;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_MVN = 2'b11;

   typedef struct packed {
      logic       w;
      logic       write;
      logic [1:0] vsel;
      logic       loada;
      logic       loadb;
      logic       loadc;
      logic       loads;
      logic       asel;
      logic [1:0] shift;
      logic [1:0] alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '{w: 1'b1, vsel: VSEL_NONE, shift: 2'b00,
                                   alu_op: ALU_ADD, default: 1'b0};

endpackage

// File: rtl/cpu_controller_instr_dec.sv
// Combinational instruction decoder: splits IR into fields, sign-extends
// immediates and classifies the instruction.
module instr_dec
   import cpu_ctrl_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
) (
   input  logic [DATA_W-1:0] ir,
   output logic [REG_AW-1:0] rn,
   output logic [REG_AW-1:0] rd,
   output logic [REG_AW-1:0] rm,
   output logic [1:0]        shift,
   output logic [1:0]        op,
   output logic [DATA_W-1:0] sximm5,
   output logic [DATA_W-1:0] sximm8,
   output logic              is_mov_imm,
   output logic              is_mov_reg,
   output logic              is_alu,
   output logic              is_cmp,
   output logic              illegal
);

   logic [2:0] opcode;

   assign opcode = ir[15:13];
   assign op     = ir[12:11];
   assign rn     = ir[8 +: REG_AW];
   assign rd     = ir[5 +: REG_AW];
   assign rm     = ir[0 +: REG_AW];
   assign shift  = ir[4:3];

   assign sximm5 = {{(DATA_W-5){ir[4]}}, ir[4:0]};
   assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};

   assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
   assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
   assign is_alu     = (opcode == OPC_ALU);
   assign is_cmp     = is_alu && (op == OP_CMP);
   assign illegal    = !(is_mov_imm || is_mov_reg || is_alu);

endmodule

// File: rtl/cpu_controller.sv
// Instruction register, Moore control FSM and registered datapath controls.
// Define CTRL_HALT_EN to stop in HALT on an illegal instruction.
module cpu_controller
   import cpu_ctrl_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s,
   input  logic              load,
   input  logic [DATA_W-1:0] in,
   output logic              w,
   output logic              halted,
   output logic              write,
   output logic [1:0]        vsel,
   output logic              loada,
   output logic              loadb,
   output logic              loadc,
   output logic              loads,
   output logic              asel,
   output logic              bsel,
   output logic [REG_AW-1:0] readnum,
   output logic [REG_AW-1:0] writenum,
   output logic [1:0]        shift,
   output logic [1:0]        ALUop,
   output logic [DATA_W-1:0] sximm5,
   output logic [DATA_W-1:0] sximm8
);

   state_t            state;
   state_t            next_state;
   logic [DATA_W-1:0] ir;
   ctrl_t             ctl;

   logic [REG_AW-1:0] rn, rd, rm;
   logic [1:0]        ir_shift, ir_op;
   logic              is_mov_imm, is_mov_reg, is_alu, is_cmp, illegal;

   instr_dec #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_dec (
      .ir         (ir),
      .rn         (rn),
      .rd         (rd),
      .rm         (rm),
      .shift      (ir_shift),
      .op         (ir_op),
      .sximm5     (sximm5),
      .sximm8     (sximm8),
      .is_mov_imm (is_mov_imm),
      .is_mov_reg (is_mov_reg),
      .is_alu     (is_alu),
      .is_cmp     (is_cmp),
      .illegal    (illegal)
   );

   always_comb begin
      next_state = state;
      unique case (state)
         S_WAIT:   if (s) next_state = S_DECODE;
         S_DECODE: begin
            if (is_mov_imm)      next_state = S_WIMM;
            else if (is_mov_reg) next_state = S_GETB;
            else if (is_alu)     next_state = S_GETA;
            else if (illegal) begin
`ifdef CTRL_HALT_EN
               next_state = S_HALT;
`else
               next_state = S_WAIT;
`endif
            end
         end
         S_WIMM:   next_state = S_WAIT;
         S_GETA:   next_state = S_GETB;
         S_GETB:   next_state = S_ALU;
         S_ALU:    next_state = is_cmp ? S_WAIT : S_WREG;
         S_WREG:   next_state = S_WAIT;
`ifdef CTRL_HALT_EN
         S_HALT:   next_state = S_HALT;
`endif
         default:  next_state = S_WAIT;
      endcase
   end

   // Outputs are registered from the state being entered; IR cannot change
   // outside WAIT, so the decode of the current IR is valid for that state.
   function automatic ctrl_t ctrl_of(input state_t st);
      ctrl_t c;
      c = '0;
      unique case (st)
         S_WAIT: c = CTRL_IDLE;
         S_WIMM: begin
            c.write = 1'b1;
            c.vsel  = VSEL_IMM8;
         end
         S_GETA: c.loada = 1'b1;
         S_GETB: c.loadb = 1'b1;
         S_ALU: begin
            c.shift  = ir_shift;
            c.alu_op = is_alu ? ir_op : ALU_ADD;
            c.asel   = is_mov_reg;
            c.loads  = is_cmp;
            c.loadc  = !is_cmp;
         end
         S_WREG: begin
            c.write = 1'b1;
            c.vsel  = VSEL_C;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   function automatic logic [REG_AW-1:0] readnum_of(input state_t st);
      if (st == S_GETA)      return rn;
      else if (st == S_GETB) return rm;
      else                   return '0;
   endfunction

   function automatic logic [REG_AW-1:0] writenum_of(input state_t st);
      if (st == S_WIMM)      return rn;
      else if (st == S_WREG) return rd;
      else                   return '0;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_WAIT;
         ir       <= '0;
         ctl      <= CTRL_IDLE;
         readnum  <= '0;
         writenum <= '0;
      end else begin
         if (state == S_WAIT && load) ir <= in;
         state    <= next_state;
         ctl      <= ctrl_of(next_state);
         readnum  <= readnum_of(next_state);
         writenum <= writenum_of(next_state);
      end
   end

`ifdef CTRL_HALT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) halted <= 1'b0;
      else       halted <= (next_state == S_HALT);
   end
`else
   assign halted = 1'b0;
`endif

   assign w     = ctl.w;
   assign write = ctl.write;
   assign vsel  = ctl.vsel;
   assign loada = ctl.loada;
   assign loadb = ctl.loadb;
   assign loadc = ctl.loadc;
   assign loads = ctl.loads;
   assign asel  = ctl.asel;
   assign bsel  = 1'b0;
   assign shift = ctl.shift;
   assign ALUop = ctl.alu_op;

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: directed and random instructions
// compared cycle by cycle against a per-instruction micro-op sequence model.
`timescale 1ns/1ps
module tb_cpu_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        s = 1'b0;
   logic        load = 1'b0;
   logic [15:0] in = '0;
   logic        w, halted, write, loada, loadb, loadc, loads, asel, bsel;
   logic [1:0]  vsel, shift, ALUop;
   logic [2:0]  readnum, writenum;
   logic [15:0] sximm5, sximm8;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic       w, halted, write;
      logic [1:0] vsel;
      logic       loada, loadb, loadc, loads, asel, bsel;
      logic [2:0] readnum, writenum;
      logic [1:0] shift, aluop;
   } obs_t;

   obs_t        exp_q[$];
   logic [15:0] model_ir = '0;

   cpu_controller #(.DATA_W(16), .REG_AW(3)) dut (
      .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
      .w(w), .halted(halted), .write(write), .vsel(vsel),
      .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
      .asel(asel), .bsel(bsel), .readnum(readnum), .writenum(writenum),
      .shift(shift), .ALUop(ALUop), .sximm5(sximm5), .sximm8(sximm8)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got=running want=finished");
      $fatal(1, "watchdog");
   end

   function automatic obs_t idle();
      obs_t o;
      o = '0;
      o.w = 1'b1;
      return o;
   endfunction

   function automatic obs_t now_obs();
      obs_t o;
      o.w = w; o.halted = halted; o.write = write; o.vsel = vsel;
      o.loada = loada; o.loadb = loadb; o.loadc = loadc; o.loads = loads;
      o.asel = asel; o.bsel = bsel; o.readnum = readnum; o.writenum = writenum;
      o.shift = shift; o.aluop = ALUop;
      return o;
   endfunction

   function automatic logic [15:0] sext(input logic [15:0] v, input int bits);
      int x;
      x = int'(v) & ((1 << bits) - 1);
      if (x >= (1 << (bits - 1))) x -= (1 << bits);
      return 16'(x);
   endfunction

   // Expected control vector for each edge after the s-sampled edge.
   function automatic void plan(input logic [15:0] ir);
      logic [2:0] opc;
      logic [1:0] op;
      bit         alu, cmp;
      obs_t       o;
      opc = ir[15:13];
      op  = ir[12:11];
      alu = (opc == 3'b101);
      cmp = alu && (op == 2'b01);
      exp_q.push_back(obs_t'(0));
      if (opc == 3'b110 && op == 2'b10) begin
         o = '0; o.write = 1'b1; o.vsel = 2'b01; o.writenum = ir[10:8];
         exp_q.push_back(o);
      end else if ((opc == 3'b110 && op == 2'b00) || alu) begin
         if (alu) begin
            o = '0; o.readnum = ir[10:8]; o.loada = 1'b1;
            exp_q.push_back(o);
         end
         o = '0; o.readnum = ir[2:0]; o.loadb = 1'b1;
         exp_q.push_back(o);
         o = '0; o.shift = ir[4:3]; o.aluop = alu ? op : 2'b00; o.asel = !alu;
         if (cmp) o.loads = 1'b1; else o.loadc = 1'b1;
         exp_q.push_back(o);
         if (!cmp) begin
            o = '0; o.writenum = ir[7:5]; o.vsel = 2'b11; o.write = 1'b1;
            exp_q.push_back(o);
         end
      end else begin
`ifdef CTRL_HALT_EN
         o = '0; o.halted = 1'b1;
         repeat (4) exp_q.push_back(o);
         return;
`endif
      end
      exp_q.push_back(idle());
   endfunction

   // Load ir, assert s, then compare every cycle; s stays high until the
   // last expected step so that reps>1 exercises immediate restart.
   task automatic execute(input logic [15:0] ir, input int reps, input string name);
      int   step;
      obs_t e;
      @(negedge clk);
      load = 1'b1; in = ir; model_ir = ir;
      @(negedge clk);
      load = 1'b0; in = 16'($urandom);
      checks++;
      if ({sximm5, sximm8} !== {sext(model_ir, 5), sext(model_ir, 8)}) begin
         failures++;
         $display("FAIL %s imm_after_load got=%h/%h want=%h/%h", name, sximm5, sximm8,
                  sext(model_ir, 5), sext(model_ir, 8));
      end
      for (int r = 0; r < reps; r++) plan(ir);
      s = 1'b1;
      @(posedge clk);
      step = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e = exp_q.pop_front();
         s = (exp_q.size() > 0);
         load = (exp_q.size() > 0 && !e.w) ? 1'($urandom) : 1'b0;
         in = 16'($urandom);
         checks++;
         if (now_obs() !== e) begin
            failures++;
            $display("FAIL %s ctrl step %0d got=%h want=%h", name, step, now_obs(), e);
         end
         checks++;
         if ({sximm5, sximm8} !== {sext(model_ir, 5), sext(model_ir, 8)}) begin
            failures++;
            $display("FAIL %s imm step %0d got=%h/%h want=%h/%h", name, step, sximm5,
                     sximm8, sext(model_ir, 5), sext(model_ir, 8));
         end
         step++;
      end
   endtask

   task automatic pulse_reset(input string name);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_ir = '0;
      checks++;
      if (now_obs() !== idle() || sximm8 !== 16'h0000) begin
         failures++;
         $display("FAIL %s post_reset got=%h/%h want=%h/0000", name, now_obs(), sximm8, idle());
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (now_obs() !== idle()) begin
         failures++;
         $display("FAIL reset_ctrl got=%h want=%h", now_obs(), idle());
      end
      checks++;
      if ({sximm5, sximm8} !== 32'h0) begin
         failures++;
         $display("FAIL reset_imm got=%h/%h want=0000/0000", sximm5, sximm8);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_mov_imm();
      execute(16'hD007, 1, "mov_r0_7");
      execute(16'hD1FE, 1, "mov_r1_neg2");
      execute(16'hD780, 1, "mov_r7_min");
   endtask

   task automatic test_mov_reg();
      execute(16'hC0E2, 1, "mov_r7_r2");
      execute(16'hC0B1, 1, "mov_r5_r1_lsr");
   endtask

   task automatic test_alu();
      execute(16'hA148, 1, "add_r2_r1_r0");
      execute(16'hA801, 1, "cmp_r0_r1");
      execute(16'hB27B, 1, "and_r3_r2_r3");
      execute(16'hB8F5, 1, "mvn_r7_r5");
   endtask

   task automatic test_illegal();
      execute(16'h0000, 1, "illegal_0000");
      pulse_reset("illegal_0000");
      execute(16'hC800, 1, "illegal_mov_op01");
      pulse_reset("illegal_mov_op01");
   endtask

   task automatic test_back_to_back();
      execute(16'hD3F0, 2, "b2b_mov_imm");
      execute(16'hA148, 3, "b2b_add");
   endtask

   task automatic test_reset_mid();
      obs_t e;
      @(negedge clk);
      load = 1'b1; in = 16'hA148; model_ir = 16'hA148;
      @(negedge clk);
      load = 1'b0;
      plan(16'hA148);
      s = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         s = 1'b0;
         e = exp_q.pop_front();
         checks++;
         if (now_obs() !== e) begin
            failures++;
            $display("FAIL reset_mid ctrl step %0d got=%h want=%h", i, now_obs(), e);
         end
      end
      exp_q.delete();
      #2 reset = 1'b1;
      #1;
      checks++;
      if (w !== 1'b1 || write !== 1'b0 || loadc !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid async got=w%b write%b loadc%b want=w1 write0 loadc0", w, write, loadc);
      end
      checks++;
      if ({sximm5, sximm8} !== 32'h0) begin
         failures++;
         $display("FAIL reset_mid ir got=%h/%h want=0000/0000", sximm5, sximm8);
      end
      @(negedge clk);
      reset = 1'b0;
      model_ir = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (now_obs() !== idle()) begin
            failures++;
            $display("FAIL reset_mid after %0d got=%h want=%h", i, now_obs(), idle());
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] r;
      logic [15:0] ir;
      int          kind;
      for (int n = 0; n < 40; n++) begin
         r = $urandom;
         ir = r[15:0];
         kind = $urandom_range(0, 4);
         case (kind)
            0: ir[15:11] = 5'b11010;
            1: ir[15:11] = 5'b11000;
            2, 3: ir[15:13] = 3'b101;
            default: begin
               if (r[16]) begin ir[15:13] = 3'b110; ir[11] = 1'b1; end
               else ir[15] = 1'b0;
            end
         endcase
         execute(ir, 1 + int'(r[17]), $sformatf("rand_%0d_%h", n, ir));
         if (kind == 4) pulse_reset($sformatf("rand_%0d", n));
      end
   endtask

   initial begin
      test_reset();
      test_mov_imm();
      test_mov_reg();
      test_alu();
      test_illegal();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
